// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field layout and the
// fetch sequencer state encoding, common to the fetch unit, ALU and store.
package cpu_pkg;

    localparam int FIELD_W    = 4;
    localparam int NUM_FIELDS = 4;

    // Nibble positions within the 16-bit instruction word
    localparam int OPCODE_LSB = 12;
    localparam int ADDR_A_LSB = 8;
    localparam int ADDR_B_LSB = 4;
    localparam int ADDR_D_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HALT   = 3'd5
    } fsm_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_DIV);
    endfunction

    function automatic logic is_halt_op(input logic [3:0] op);
        return (op == OP_HALT);
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational split of the instruction register into its four nibble
// fields, plus HALT / reserved / ALU classification of the opcode.
module instruction_decoder
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 16
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [3:0]             opcode,
    output logic [3:0]             addr_a,
    output logic [3:0]             addr_b,
    output logic [3:0]             addr_d,
    output logic                   is_halt,
    output logic                   is_reserved,
    output logic                   is_alu
);

    logic [FIELD_W-1:0] field [NUM_FIELDS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            assign field[gi] = instr[gi*FIELD_W +: FIELD_W];
        end
    endgenerate

    assign opcode = field[OPCODE_LSB / FIELD_W];
    assign addr_a = field[ADDR_A_LSB / FIELD_W];
    assign addr_b = field[ADDR_B_LSB / FIELD_W];
    assign addr_d = field[ADDR_D_LSB / FIELD_W];

    assign is_halt     = is_halt_op(opcode);
    assign is_alu      = is_alu_op(opcode);
    assign is_reserved = !is_halt && !is_alu;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Control front end: walks the program counter, latches and decodes each
// word, hands ALU operations over valid/ready and waits for completion.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 16,
    parameter int LAST_ADDR   = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    program_counter,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [3:0]             opcode,
    output logic [3:0]             addr_a,
    output logic [3:0]             addr_b,
    output logic [3:0]             addr_d,
    input  logic                   alu_done,
    output logic                   illegal,
    output logic                   busy,
    output logic                   halted
);

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(LAST_ADDR);

    fsm_state_t             state_reg, state_next;
    logic [PC_WIDTH-1:0]    pc_reg, pc_next;
    logic [INSTR_WIDTH-1:0] ir_reg, ir_next;
    logic [3:0]             opcode_reg, opcode_next;
    logic [3:0]             addr_a_reg, addr_a_next;
    logic [3:0]             addr_b_reg, addr_b_next;
    logic [3:0]             addr_d_reg, addr_d_next;

    logic [3:0] dec_opcode, dec_addr_a, dec_addr_b, dec_addr_d;
    logic       dec_is_halt, dec_is_reserved, dec_is_alu;

    instruction_decoder #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_decoder (
        .instr       (ir_reg),
        .opcode      (dec_opcode),
        .addr_a      (dec_addr_a),
        .addr_b      (dec_addr_b),
        .addr_d      (dec_addr_d),
        .is_halt     (dec_is_halt),
        .is_reserved (dec_is_reserved),
        .is_alu      (dec_is_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            ir_reg     <= '0;
            opcode_reg <= '0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            addr_d_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            opcode_reg <= opcode_next;
            addr_a_reg <= addr_a_next;
            addr_b_reg <= addr_b_next;
            addr_d_reg <= addr_d_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        opcode_next = opcode_reg;
        addr_a_next = addr_a_reg;
        addr_b_next = addr_b_reg;
        addr_d_next = addr_d_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ir_next    = instruction;
                state_next = ST_DECODE;
            end

            ST_DECODE: begin
                opcode_next = dec_opcode;
                addr_a_next = dec_addr_a;
                addr_b_next = dec_addr_b;
                addr_d_next = dec_addr_d;
                if (dec_is_halt) begin
                    state_next = ST_HALT;
                end else if (dec_is_alu) begin
                    state_next = ST_ISSUE;
                end else if (pc_reg == LAST_PC) begin
                    state_next = ST_HALT;
                end else begin
                    pc_next    = pc_reg + PC_WIDTH'(1);
                    state_next = ST_FETCH;
                end
            end

            ST_ISSUE: begin
                if (op_ready) begin
                    state_next = ST_WAIT;
                end
            end

            // The program terminates at LAST_ADDR rather than wrapping to 0
            ST_WAIT: begin
                if (alu_done) begin
                    if (pc_reg == LAST_PC) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next    = pc_reg + PC_WIDTH'(1);
                        state_next = ST_FETCH;
                    end
                end
            end

            ST_HALT: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign program_counter = pc_reg;
    assign opcode          = opcode_reg;
    assign addr_a          = addr_a_reg;
    assign addr_b          = addr_b_reg;
    assign addr_d          = addr_d_reg;
    assign op_valid        = (state_reg == ST_ISSUE);
    assign illegal         = (state_reg == ST_DECODE) && dec_is_reserved;
    assign busy            = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halted          = (state_reg == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a program-walk model predicts the
// issue/illegal sequence and halt address; a per-cycle monitor compares.
module tb_instruction_fetch_unit;

    localparam int LAST_ADDR = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        op_ready = 1'b0;
    logic        alu_done = 1'b0;
    logic [3:0]  program_counter;
    logic [15:0] instruction;
    logic        op_valid;
    logic [3:0]  opcode, addr_a, addr_b, addr_d;
    logic        illegal, busy, halted;

    logic [15:0] mem [16];
    assign instruction = mem[program_counter];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .PC_WIDTH    (4),
        .INSTR_WIDTH (16),
        .LAST_ADDR   (LAST_ADDR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .program_counter (program_counter),
        .instruction     (instruction),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .opcode          (opcode),
        .addr_a          (addr_a),
        .addr_b          (addr_b),
        .addr_d          (addr_d),
        .alu_done        (alu_done),
        .illegal         (illegal),
        .busy            (busy),
        .halted          (halted)
    );

    typedef struct {
        int op;
        int a;
        int b;
        int d;
        int pc;
    } issue_t;

    issue_t exp_issue[$];
    int     exp_illegal[$];
    int     exp_halt_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int issue_seen, illegal_seen, valid_cycles;
    bit chk_en = 1'b0;

    int ready_delay = 0;
    int done_delay  = 0;
    bit stray_done  = 1'b0;
    int stall_cnt = 0;
    int done_cnt  = 0;
    bit wait_active = 1'b0;
    bit hs_next = 1'b0;
    bit in_wait = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Walk the program by the architectural rules: HALT stops in place, ALU
    // words issue, reserved words are flagged, LAST_ADDR ends the program.
    task automatic build_model();
        int pc;
        int op;
        logic [15:0] w;
        exp_issue.delete();
        exp_illegal.delete();
        exp_halt_pc = -1;
        pc = 0;
        for (int guard = 0; guard < 32; guard++) begin
            w  = mem[pc];
            op = int'(w[15:12]);
            if (op == 15) begin
                exp_halt_pc = pc;
                break;
            end
            if (op <= 5)
                exp_issue.push_back(issue_t'{op, int'(w[11:8]), int'(w[7:4]), int'(w[3:0]), pc});
            else
                exp_illegal.push_back(pc);
            if (pc == LAST_ADDR) begin
                exp_halt_pc = pc;
                break;
            end
            pc++;
        end
    endtask

    // ALU side: stalls op_ready for ready_delay cycles, returns alu_done
    // done_delay cycles into WAIT, optionally toggles alu_done elsewhere.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            wait_active = 1'b0;
            hs_next     = 1'b0;
            in_wait     = 1'b0;
            stall_cnt   = 0;
            alu_done    = 1'b0;
            op_ready    = 1'b0;
        end else begin
            alu_done = 1'b0;
            if (hs_next) begin
                done_cnt    = done_delay;
                wait_active = 1'b1;
            end
            in_wait = wait_active;
            if (wait_active) begin
                if (done_cnt == 0) begin
                    alu_done    = 1'b1;
                    wait_active = 1'b0;
                end else begin
                    done_cnt--;
                end
            end else if (stray_done && busy) begin
                alu_done = 1'b1;
            end
            if (op_valid) begin
                if (stall_cnt < ready_delay) begin
                    op_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    op_ready = 1'b1;
                end
            end else begin
                op_ready  = 1'b0;
                stall_cnt = 0;
            end
            hs_next = op_valid && op_ready;
        end
    end

    bit         prev_valid = 1'b0;
    bit         prev_ready = 1'b0;
    bit         prev_busy  = 1'b0;
    logic [3:0] prev_pc    = '0;

    always @(negedge clk) begin
        if (!chk_en || !rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (op_valid) begin
                valid_cycles++;
                if (exp_issue.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    check("issue_opcode", int'(opcode), exp_issue[0].op);
                    check("issue_addr_a", int'(addr_a), exp_issue[0].a);
                    check("issue_addr_b", int'(addr_b), exp_issue[0].b);
                    check("issue_addr_d", int'(addr_d), exp_issue[0].d);
                    check("issue_pc", int'(program_counter), exp_issue[0].pc);
                    if (op_ready) begin
                        $display("[TB] issue pc=%0d op=%0d a=%0d b=%0d d=%0d",
                                 program_counter, opcode, addr_a, addr_b, addr_d);
                        issue_seen++;
                        void'(exp_issue.pop_front());
                    end
                end
            end
            if (illegal) begin
                check("illegal_with_valid", int'(op_valid), 0);
                if (exp_illegal.size() == 0) begin
                    check("illegal_unexpected", 1, 0);
                end else begin
                    check("illegal_pc", int'(program_counter), exp_illegal[0]);
                    $display("[TB] illegal pc=%0d", program_counter);
                    illegal_seen++;
                    void'(exp_illegal.pop_front());
                end
            end
            if (prev_valid && !prev_ready)
                check("op_valid_held", int'(op_valid), 1);
            if (prev_busy && busy && program_counter != prev_pc)
                check("pc_step", int'(program_counter), int'(prev_pc) + 1);
            check("halted_busy_excl", int'(halted && busy), 0);
            prev_valid = op_valid;
            prev_ready = op_ready;
            prev_busy  = busy;
            prev_pc    = program_counter;
        end
    end

    task automatic run_program(input string name, input bit start_in_wait, output int first_valid);
        int cyc;
        bit pulsed;
        issue_seen   = 0;
        illegal_seen = 0;
        valid_cycles = 0;
        first_valid  = -1;
        pulsed       = 1'b0;
        chk_en       = 1'b1;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        cyc = 1;
        while (!halted && cyc < 600) begin
            @(negedge clk);
            if (op_valid && first_valid < 0) first_valid = cyc;
            @(posedge clk); #2;
            cyc++;
            if (start_in_wait && !pulsed && in_wait) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, "_halt_reached"}, int'(halted), 1);
        check({name, "_halt_pc"}, int'(program_counter), exp_halt_pc);
        check({name, "_pending_issues"}, exp_issue.size(), 0);
        check({name, "_pending_illegal"}, exp_illegal.size(), 0);
        check({name, "_busy_after"}, int'(busy), 0);
        $display("[TB] run %s: halted pc=%0d cycles=%0d issues=%0d illegal=%0d",
                 name, program_counter, cyc, issue_seen, illegal_seen);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'hF000;
    endtask

    int fv;
    int guard_cnt;

    initial begin
        clear_mem();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", int'(program_counter), 0);
        check("rst_opcode", int'(opcode), 0);
        check("rst_addr_a", int'(addr_a), 0);
        check("rst_addr_b", int'(addr_b), 0);
        check("rst_addr_d", int'(addr_d), 0);
        check("rst_op_valid", int'(op_valid), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_halted", int'(halted), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_busy", int'(busy), 0);

        // ADD, SUB, HALT with immediate ready and one-cycle done
        clear_mem();
        mem[0] = 16'h0010; mem[1] = 16'h1230; mem[2] = 16'hF000;
        build_model();
        check("t1_model_issues", exp_issue.size(), 2);
        check("t1_model_op0", exp_issue[0].op, 0);
        check("t1_model_b0", exp_issue[0].b, 1);
        check("t1_model_a1", exp_issue[1].a, 2);
        check("t1_model_b1", exp_issue[1].b, 3);
        check("t1_model_halt", exp_halt_pc, 2);
        run_program("t1", 1'b0, fv);
        check("t1_first_valid_cycle", fv, 3);
        check("t1_issue_count", issue_seen, 2);
        check("t1_halt_pc_literal", int'(program_counter), 2);

        // Rerun from HALT with a start pulse during WAIT
        done_delay = 2;
        build_model();
        run_program("t1_rerun", 1'b1, fv);
        check("t1r_first_valid_cycle", fv, 3);
        check("t1r_issue_count", issue_seen, 2);
        done_delay = 0;

        // MUL held off by op_ready for 5 cycles, stray alu_done meanwhile
        clear_mem();
        mem[0] = 16'h4810;
        build_model();
        check("t2_model_a", exp_issue[0].a, 8);
        ready_delay = 5;
        stray_done  = 1'b1;
        run_program("t2", 1'b0, fv);
        check("t2_valid_cycles", valid_cycles, 6);
        check("t2_issue_count", issue_seen, 1);
        ready_delay = 0;
        stray_done  = 1'b0;

        // Reserved opcode at address 1
        clear_mem();
        mem[0] = 16'h0123; mem[1] = 16'h7000; mem[2] = 16'h3456; mem[3] = 16'hF000;
        build_model();
        check("t3_model_illegal_pc", exp_illegal[0], 1);
        run_program("t3", 1'b0, fv);
        check("t3_illegal_count", illegal_seen, 1);
        check("t3_issue_count", issue_seen, 2);
        check("t3_halt_pc_literal", int'(program_counter), 3);

        // Sixteen ADDs run off the end of the store
        for (int i = 0; i < 16; i++) mem[i] = {4'h0, 4'(i), 4'(15 - i), 4'(i)};
        build_model();
        check("t4_model_halt", exp_halt_pc, 15);
        done_delay = 1;
        stray_done = 1'b1;
        run_program("t4", 1'b0, fv);
        check("t4_issue_count", issue_seen, 16);
        check("t4_halt_pc_literal", int'(program_counter), 15);
        done_delay = 0;
        stray_done = 1'b0;

        // Asynchronous reset while an operation sits in ISSUE
        clear_mem();
        mem[0] = 16'h7000; mem[1] = 16'h8000; mem[2] = 16'h2345; mem[3] = 16'hF000;
        build_model();
        ready_delay = 1000;
        chk_en = 1'b1;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        guard_cnt = 0;
        while (!op_valid && guard_cnt < 20) begin
            @(posedge clk); #2;
            guard_cnt++;
        end
        check("t5_reached_issue", int'(op_valid), 1);
        check("t5_pc_before_reset", int'(program_counter), 2);
        repeat (2) @(posedge clk);
        #3 chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_op_valid", int'(op_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_pc", int'(program_counter), 0);
        check("t5_rst_halted", int'(halted), 0);
        check("t5_rst_opcode", int'(opcode), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ready_delay = 0;
        build_model();
        run_program("t5_restart", 1'b0, fv);
        check("t5_first_valid_cycle", fv, 7);
        check("t5_illegal_count", illegal_seen, 2);
        check("t5_issue_count", issue_seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer that drives the instruction store's 4-bit `program_counter` and consumes the returned 16-bit instruction word. It latches each word and splits it into opcode and operand addresses. It issues each operation to the ALU/datapath over a valid/ready handshake, then waits for completion before advancing. It sits between the instruction store and the ALU as the CPU's control front end.

## Interface
Parameters:
- `PC_WIDTH`, 4, program counter width; the store holds 2^PC_WIDTH words.
- `INSTR_WIDTH`, 16, instruction word width.
- `LAST_ADDR`, 15, final program address; the block halts after completing it.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins execution at address 0. Honoured only in IDLE or HALT.
- `program_counter`  out  PC_WIDTH  address to the instruction store. Registered.
- `instruction`  in  INSTR_WIDTH  word read combinationally from the store at `program_counter`.
- `op_valid`  out  1  decoded operation is presented.
- `op_ready`  in  1  ALU accepts the operation.
- `opcode`  out  4  bits [15:12] of the latched word.
- `addr_a`  out  4  bits [11:8].
- `addr_b`  out  4  bits [7:4].
- `addr_d`  out  4  bits [3:0].
- `alu_done`  in  1  the accepted operation has completed.
- `illegal`  out  1  one-cycle pulse when a reserved opcode is skipped.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV.
  - 6–14 reserved.
  - 15 HALT.
- FSM states: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT.
- IDLE: PC = 0.
  - `start` → FETCH.
- FETCH: capture `instruction` into the internal instruction register.
  - → DECODE.
- DECODE: load `opcode`/`addr_a`/`addr_b`/`addr_d` from the instruction register.
  - HALT opcode → HALT; PC holds the HALT address.
  - Reserved opcode → pulse `illegal`. Then advance:
    - if PC == LAST_ADDR → HALT;
    - otherwise PC+1, → FETCH.
  - Valid ALU opcode → ISSUE.
- ISSUE: `op_valid` = 1; field outputs held stable.
  - Transfer occurs on a cycle with `op_valid && op_ready` → WAIT. `op_valid` deasserts the next cycle.
  - `op_valid` is never withdrawn before the transfer.
- WAIT: sample `alu_done` each cycle.
  - On `alu_done`: if PC == LAST_ADDR → HALT; otherwise PC+1, → FETCH.
  - `alu_done` in any other state is ignored.
- HALT: `start` → PC = 0, → FETCH. A program is re-runnable without reset.
- `start` while busy: ignored.
- PC never wraps. Reaching LAST_ADDR terminates the program.
- Every programmed region must end in HALT or run to LAST_ADDR. Words containing X/Z are outside the contract.

## Timing
- Reset values:
  - state IDLE, `program_counter` 0;
  - `opcode`/`addr_*` 0;
  - `op_valid` 0, `illegal` 0, `busy` 0, `halted` 0.
- Reset mid-operation clears all of the above immediately (asynchronous). `op_valid` drops without completing the handshake.
- With `start` sampled at cycle 0: FETCH at cycle 1, DECODE at cycle 2, `op_valid` first high at cycle 3.
- Minimum per ALU instruction is 4 cycles: FETCH, DECODE, ISSUE with `op_ready`=1, WAIT with `alu_done`=1.
- A reserved opcode costs 2 cycles (FETCH, DECODE). `illegal` is high during the cycle the FSM is in DECODE.
- `program_counter` changes only on the FETCH-entry edge (increment or reset to 0). It is stable from FETCH through WAIT.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (`OP_ADD`…`OP_DIV`, `OP_HALT`);
  - field bit positions;
  - the FSM state encoding.
  The ALU and the instruction store use the same constants.
- Sub-module `instruction_decoder` is combinational. It takes the instruction register and produces the field split plus `is_halt`/`is_reserved`/`is_alu` classification.
- FSM, PC and output registers live in the top module.

## Test plan
- Program {0x0010, 0x1230, 0xF000}, `op_ready`=1, `alu_done` returned 1 cycle after each transfer:
  - ADD then SUB issued;
  - `opcode`/`addr_a`/`addr_b` = 0/0/1 and 1/2/3;
  - `halted` at PC=2;
  - first `op_valid` at cycle 3.
- Hold `op_ready`=0 for 5 cycles on 0x4810:
  - `op_valid` stays high throughout;
  - `opcode`=4, `addr_a`=8, `addr_b`=1 stable;
  - PC unchanged.
- Word 0x7000 at address 1:
  - one-cycle `illegal` pulse;
  - no `op_valid` for it;
  - execution continues at address 2.
- 16 ADD words, LAST_ADDR=15:
  - 16 issues;
  - `halted`=1 with PC=15;
  - PC never returns to 0.
- Assert `rst_n`=0 during ISSUE:
  - `op_valid`, `busy`, PC all 0 immediately;
  - after release plus `start`, the program restarts at address 0.
- `start` pulsed while in WAIT: ignored. `start` in HALT: rerun from address 0 with identical issue sequence.
